apb4_ahb3lite_bridge: RTL and testbench
=======================================

Name: apb4_ahb3lite_bridge

Overview:
APB4 slave to AHB3-lite master bridge. It is the reverse of the SoC's AHB-to-APB bridge. It lets an APB-side agent (debug/host port, DMA control bus) issue single transfers onto the AHB3-lite interconnect as an extra master port. Each APB transfer maps to exactly one AHB SINGLE NONSEQ transfer, with byte strobes translated to HSIZE/HADDR[1:0].

Parameters:
PADDR_SIZE, 32, APB address width (1..32).
HADDR_BASE, 32'h0000_0000, supplies HADDR[31:PADDR_SIZE] when PADDR_SIZE<32.
HPROT_CACHE, 2'b00, constant HPROT[3:2] (bufferable, cacheable).

Ports:
CLK  in  1  single clock, APB and AHB sides.
RESET  in  1  synchronous, active-high reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  APB direction.
PPROT  in  3  APB protection.
PSTRB  in  4  APB write byte strobes.
PADDR  in  PADDR_SIZE  APB address.
PWDATA  in  32  APB write data.
PRDATA  out  32  APB read data.
PREADY  out  1  APB transfer complete.
PSLVERR  out  1  APB error.
HSEL  out  1  interconnect master-port enable, constant 1.
HADDR  out  32  AHB address.
HWDATA  out  32  AHB write data.
HTRANS  out  2  AHB transfer type.
HSIZE  out  3  AHB size.
HBURST  out  3  constant 3'b000 (SINGLE).
HPROT  out  4  AHB protection.
HWRITE  out  1  AHB direction.
HMASTLOCK  out  1  constant 0.
HRDATA  in  32  AHB read data.
HRESP  in  1  AHB response (1 = ERROR).
HREADY  in  1  AHB ready.

Behaviour:
- Reset values (sync, active-high): state=IDLE, HTRANS=2'b00, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=3'b010, HPROT=4'b0011, PRDATA=0, PREADY=0, PSLVERR=0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE, on PSEL & !PENABLE (APB setup phase): latch PADDR, PWRITE, PSTRB, PWDATA, PPROT, then decode.
- Strobe decode for writes:
  - 1111: HSIZE=word, HADDR[1:0]=00.
  - 0011 / 1100: halfword, HADDR[1:0]=00 / 10.
  - 0001 / 0010 / 0100 / 1000: byte, HADDR[1:0]=00 / 01 / 10 / 11.
  - Any other pattern, including 0000: illegal. Go to RESP with error=1, no AHB transfer.
- Reads: HSIZE=word, HADDR[1:0]=00, PSTRB ignored.
- PADDR[1:0] is always ignored. HADDR = {HADDR_BASE[31:PADDR_SIZE], PADDR[PADDR_SIZE-1:2], decoded[1:0]}.
- HPROT[0] = ~PPROT[2]. HPROT[1] = PPROT[0]. HPROT[3:2] = HPROT_CACHE.
- ADDR: HTRANS=NONSEQ (2'b10), address/control stable.
  - Stay while HREADY=0.
  - On HREADY=1 go to DATA. HTRANS=IDLE from the next cycle.
- DATA: HWDATA = latched PWDATA, lanes unchanged (little-endian).
  - Stay while HREADY=0, ignoring HRESP in the first error cycle.
  - On HREADY=1: capture HRDATA into PRDATA (reads only, else 0), capture HRESP into error, go to RESP.
- RESP: PREADY=1 and PSLVERR=error for exactly one cycle, then IDLE.
  - PRDATA holds its value until the next capture.
  - Back-to-back APB setup is accepted the cycle after RESP.
- Latency with zero AHB wait states: setup at T0, NONSEQ at T1, data phase at T2, PREADY at T3.
- Each AHB wait state adds one cycle.
- Illegal-strobe error: PREADY at T1.
- PREADY is 0 in every state except RESP.
- PSEL dropping mid-transfer (protocol violation): the AHB transfer still completes, RESP is still issued once, then IDLE.
- RESET asserted in any state: IDLE next cycle, all outputs to reset values, in-flight APB transfer abandoned with no PREADY. The AHB side sees HTRANS=IDLE.
- Only one outstanding transfer. There is no pipelining of consecutive APB transfers.

Test Plan:
- Word write: PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=1111, HREADY=1 -> HTRANS=NONSEQ, HADDR=0x10, HSIZE=010, HWRITE=1 at T1; HWDATA=0xDEADBEEF at T2; PREADY=1, PSLVERR=0 at T3.
- Byte write: PADDR=0x20, PSTRB=0100 -> HADDR=0x22, HSIZE=000. Halfword PSTRB=1100 -> HADDR=0x22, HSIZE=001.
- Read with 2 wait states in the data phase: HRDATA=0x12345678 on the HREADY=1 cycle -> PRDATA=0x12345678, PREADY at T5, PSLVERR=0.
- AHB error: HRESP=1 with HREADY=0 then HRESP=1 with HREADY=1 -> PSLVERR=1 with PREADY, and IDLE afterwards.
- Illegal strobe 0101 -> no NONSEQ ever driven, PREADY=1 and PSLVERR=1 at T1.
- RESET asserted while in DATA -> next cycle HTRANS=00, PREADY=0, state IDLE. A following word write completes normally in 3 cycles.

Source files
------------

// File: rtl/apb4_ahb3lite_bridge.sv
// APB4 slave to AHB3-lite master bridge: each APB access becomes one AHB SINGLE NONSEQ transfer.
// Byte strobes select HSIZE and HADDR[1:0]; illegal strobe patterns are rejected without touching AHB.
module apb4_ahb3lite_bridge #(
  parameter int          PADDR_SIZE  = 32,
  parameter logic [31:0] HADDR_BASE  = 32'h0000_0000,
  parameter logic [1:0]  HPROT_CACHE = 2'b00
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [2:0]            PPROT,
  input  logic [3:0]            PSTRB,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  HSEL,
  output logic [31:0]           HADDR,
  output logic [31:0]           HWDATA,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HWRITE,
  output logic                  HMASTLOCK,
  input  logic [31:0]           HRDATA,
  input  logic                  HRESP,
  input  logic                  HREADY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;
  localparam logic [63:0] ADDR_MASK64   = (64'd1 << PADDR_SIZE) - 64'd1;
  localparam logic [31:0] ADDR_MASK     = ADDR_MASK64[31:0];

  // Returns {legal, hsize[2:0], haddr[1:0]} for a write strobe pattern.
  function automatic logic [5:0] decode_strobe(input logic [3:0] strb);
    logic [5:0] res;
    case (strb)
      4'b1111: res = {1'b1, 3'b010, 2'b00};
      4'b0011: res = {1'b1, 3'b001, 2'b00};
      4'b1100: res = {1'b1, 3'b001, 2'b10};
      4'b0001: res = {1'b1, 3'b000, 2'b00};
      4'b0010: res = {1'b1, 3'b000, 2'b01};
      4'b0100: res = {1'b1, 3'b000, 2'b10};
      4'b1000: res = {1'b1, 3'b000, 2'b11};
      default: res = {1'b0, 3'b010, 2'b00};
    endcase
    return res;
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  htrans_r, htrans_s;
  logic [31:0] haddr_r, haddr_s;
  logic [31:0] hwdata_r, hwdata_s;
  logic [31:0] pwdata_r, pwdata_s;
  logic        hwrite_r, hwrite_s;
  logic [2:0]  hsize_r, hsize_s;
  logic [3:0]  hprot_r, hprot_s;
  logic [31:0] prdata_r, prdata_s;
  logic        pready_r, pready_s;
  logic        pslverr_r, pslverr_s;
  logic [31:0] paddr_ext_s;
  logic [31:0] haddr_word_s;
  logic [5:0]  dec_s;
  logic        unused_ok_s;

  assign unused_ok_s = ^{PPROT[1], haddr_word_s[1:0]};

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_s      = state_r;
    htrans_s     = HTRANS_IDLE;
    haddr_s      = haddr_r;
    hwdata_s     = hwdata_r;
    pwdata_s     = pwdata_r;
    hwrite_s     = hwrite_r;
    hsize_s      = hsize_r;
    hprot_s      = hprot_r;
    prdata_s     = prdata_r;
    pready_s     = 1'b0;
    pslverr_s    = 1'b0;
    paddr_ext_s  = 32'(PADDR);
    haddr_word_s = (HADDR_BASE & ~ADDR_MASK) | (paddr_ext_s & ADDR_MASK);
    if (PWRITE) begin
      dec_s = decode_strobe(PSTRB);
    end else begin
      dec_s = {1'b1, HSIZE_WORD, 2'b00};
    end

    case (state_r)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          if (dec_s[5]) begin
            state_s  = ST_ADDR;
            htrans_s = HTRANS_NONSEQ;
            haddr_s  = {haddr_word_s[31:2], dec_s[1:0]};
            hsize_s  = dec_s[4:2];
            hwrite_s = PWRITE;
            pwdata_s = PWDATA;
            hprot_s  = {HPROT_CACHE, PPROT[0], ~PPROT[2]};
          end else begin
            // Illegal strobe: answer with an error straight away, AHB stays idle.
            state_s   = ST_RESP;
            pready_s  = 1'b1;
            pslverr_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_s  = ST_DATA;
          hwdata_s = pwdata_r;
        end else begin
          htrans_s = HTRANS_NONSEQ;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          state_s   = ST_RESP;
          prdata_s  = hwrite_r ? 32'h0000_0000 : HRDATA;
          pready_s  = 1'b1;
          pslverr_s = HRESP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      htrans_r  <= HTRANS_IDLE;
      haddr_r   <= 32'h0000_0000;
      hwdata_r  <= 32'h0000_0000;
      pwdata_r  <= 32'h0000_0000;
      hwrite_r  <= 1'b0;
      hsize_r   <= HSIZE_WORD;
      hprot_r   <= 4'b0011;
      prdata_r  <= 32'h0000_0000;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      htrans_r  <= htrans_s;
      haddr_r   <= haddr_s;
      hwdata_r  <= hwdata_s;
      pwdata_r  <= pwdata_s;
      hwrite_r  <= hwrite_s;
      hsize_r   <= hsize_s;
      hprot_r   <= hprot_s;
      prdata_r  <= prdata_s;
      pready_r  <= pready_s;
      pslverr_r <= pslverr_s;
    end
  end

  assign HTRANS    = htrans_r;
  assign HADDR     = haddr_r;
  assign HWDATA    = hwdata_r;
  assign HWRITE    = hwrite_r;
  assign HSIZE     = hsize_r;
  assign HPROT     = hprot_r;
  assign PRDATA    = prdata_r;
  assign PREADY    = pready_r;
  assign PSLVERR   = pslverr_r;
  assign HSEL      = 1'b1;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_apb4_ahb3lite_bridge.sv
// Directed bench for apb4_ahb3lite_bridge: word/byte/halfword writes, waited read, AHB error,
// illegal strobes, reset in the data phase and back-to-back accesses.
module tb_apb4_ahb3lite_bridge;

  localparam int ASZ = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           PSEL, PENABLE, PWRITE;
  logic [2:0]     PPROT;
  logic [3:0]     PSTRB;
  logic [ASZ-1:0] PADDR;
  logic [31:0]    PWDATA, PRDATA;
  logic           PREADY, PSLVERR, HSEL;
  logic [31:0]    HADDR, HWDATA, HRDATA;
  logic [1:0]     HTRANS;
  logic [2:0]     HSIZE, HBURST;
  logic [3:0]     HPROT;
  logic           HWRITE, HMASTLOCK, HRESP, HREADY;

  int n_checks = 0;
  int n_fail   = 0;

  apb4_ahb3lite_bridge #(
    .PADDR_SIZE (ASZ),
    .HADDR_BASE (32'h4001_0000),
    .HPROT_CACHE(2'b10)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PPROT(PPROT), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE),
    .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apb_setup(input logic [ASZ-1:0] addr, input logic wr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [2:0] prot);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr;
    PSTRB = strb; PWDATA = wdata; PPROT = prot;
  endtask

  task automatic apb_idle();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; apb_idle(); PWRITE = 1'b0; PPROT = 3'b000; PSTRB = 4'b0000;
    PADDR = 16'h0000; PWDATA = 32'h0; HRDATA = 32'h0; HRESP = 1'b0; HREADY = 1'b1;
    tick(); tick();
    check_eq("rst_htrans", 32'(HTRANS), 32'h0);
    check_eq("rst_haddr", HADDR, 32'h0);
    check_eq("rst_hwdata", HWDATA, 32'h0);
    check_eq("rst_hwrite", 32'(HWRITE), 32'h0);
    check_eq("rst_hsize", 32'(HSIZE), 32'h2);
    check_eq("rst_hprot", 32'(HPROT), 32'h3);
    check_eq("rst_prdata", PRDATA, 32'h0);
    check_eq("rst_pready", 32'(PREADY), 32'h0);
    check_eq("rst_pslverr", 32'(PSLVERR), 32'h0);
    check_eq("hsel", 32'(HSEL), 32'h1);
    check_eq("hburst", 32'(HBURST), 32'h0);
    check_eq("hmastlock", 32'(HMASTLOCK), 32'h0);
    RESET = 1'b0;
    tick();

    // Word write, zero wait states
    apb_setup(16'h0010, 1'b1, 4'b1111, 32'hDEAD_BEEF, 3'b000);
    tick();
    check_eq("ww_htrans_t1", 32'(HTRANS), 32'h2);
    check_eq("ww_haddr", HADDR, 32'h4001_0010);
    check_eq("ww_hsize", 32'(HSIZE), 32'h2);
    check_eq("ww_hwrite", 32'(HWRITE), 32'h1);
    check_eq("ww_hprot", 32'(HPROT), 32'h9);
    check_eq("ww_pready_t1", 32'(PREADY), 32'h0);
    PENABLE = 1'b1;
    tick();
    check_eq("ww_htrans_t2", 32'(HTRANS), 32'h0);
    check_eq("ww_hwdata", HWDATA, 32'hDEAD_BEEF);
    check_eq("ww_pready_t2", 32'(PREADY), 32'h0);
    tick();
    check_eq("ww_pready_t3", 32'(PREADY), 32'h1);
    check_eq("ww_pslverr", 32'(PSLVERR), 32'h0);
    apb_idle();
    tick();
    check_eq("ww_pready_t4", 32'(PREADY), 32'h0);

    // Byte write, lane 2
    apb_setup(16'h0020, 1'b1, 4'b0100, 32'h00AB_0000, 3'b101);
    tick();
    check_eq("bw_haddr", HADDR, 32'h4001_0022);
    check_eq("bw_hsize", 32'(HSIZE), 32'h0);
    check_eq("bw_hprot", 32'(HPROT), 32'hA);
    PENABLE = 1'b1;
    tick();
    check_eq("bw_hwdata", HWDATA, 32'h00AB_0000);
    tick();
    check_eq("bw_pready", 32'(PREADY), 32'h1);
    apb_idle();
    tick();

    // Halfword write, upper half, one address-phase wait; PADDR[1:0] ignored
    apb_setup(16'h0021, 1'b1, 4'b1100, 32'hCAFE_0000, 3'b000);
    tick();
    check_eq("hw_haddr", HADDR, 32'h4001_0022);
    check_eq("hw_hsize", 32'(HSIZE), 32'h1);
    PENABLE = 1'b1; HREADY = 1'b0;
    tick();
    check_eq("hw_htrans_held", 32'(HTRANS), 32'h2);
    check_eq("hw_pready_wait", 32'(PREADY), 32'h0);
    HREADY = 1'b1;
    tick();
    check_eq("hw_htrans_data", 32'(HTRANS), 32'h0);
    check_eq("hw_hwdata", HWDATA, 32'hCAFE_0000);
    tick();
    check_eq("hw_pready", 32'(PREADY), 32'h1);
    check_eq("hw_pslverr", 32'(PSLVERR), 32'h0);
    apb_idle();
    tick();

    // Read with two data-phase wait states; strobes ignored
    apb_setup(16'h0037, 1'b0, 4'b0000, 32'h0, 3'b000);
    tick();
    check_eq("rd_htrans", 32'(HTRANS), 32'h2);
    check_eq("rd_haddr", HADDR, 32'h4001_0034);
    check_eq("rd_hsize", 32'(HSIZE), 32'h2);
    check_eq("rd_hwrite", 32'(HWRITE), 32'h0);
    PENABLE = 1'b1;
    tick();
    HREADY = 1'b0; HRDATA = 32'hBAD0_BAD0;
    tick();
    check_eq("rd_pready_t3", 32'(PREADY), 32'h0);
    tick();
    check_eq("rd_pready_t4", 32'(PREADY), 32'h0);
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    tick();
    check_eq("rd_pready_t5", 32'(PREADY), 32'h1);
    check_eq("rd_prdata", PRDATA, 32'h1234_5678);
    check_eq("rd_pslverr", 32'(PSLVERR), 32'h0);
    apb_idle(); HRDATA = 32'h0;
    tick();
    check_eq("rd_prdata_hold", PRDATA, 32'h1234_5678);
    check_eq("rd_pready_t6", 32'(PREADY), 32'h0);

    // AHB error response (two-cycle ERROR)
    apb_setup(16'h0040, 1'b1, 4'b1111, 32'h5555_AAAA, 3'b000);
    tick();
    PENABLE = 1'b1;
    tick();
    HREADY = 1'b0; HRESP = 1'b1;
    tick();
    check_eq("er_pready_first", 32'(PREADY), 32'h0);
    HREADY = 1'b1;
    tick();
    check_eq("er_pready", 32'(PREADY), 32'h1);
    check_eq("er_pslverr", 32'(PSLVERR), 32'h1);
    check_eq("er_prdata_wr", PRDATA, 32'h0);
    apb_idle(); HRESP = 1'b0;
    tick();
    check_eq("er_pready_after", 32'(PREADY), 32'h0);
    check_eq("er_pslverr_after", 32'(PSLVERR), 32'h0);
    check_eq("er_htrans_after", 32'(HTRANS), 32'h0);

    // Illegal strobes: immediate error, no NONSEQ
    apb_setup(16'h0044, 1'b1, 4'b0101, 32'h0, 3'b000);
    tick();
    check_eq("il_pready", 32'(PREADY), 32'h1);
    check_eq("il_pslverr", 32'(PSLVERR), 32'h1);
    check_eq("il_htrans", 32'(HTRANS), 32'h0);
    PENABLE = 1'b1;
    tick();
    check_eq("il_pready_t2", 32'(PREADY), 32'h0);
    check_eq("il_htrans_t2", 32'(HTRANS), 32'h0);
    apb_setup(16'h0048, 1'b1, 4'b0000, 32'h0, 3'b000);
    tick();
    check_eq("il0_pslverr", 32'(PSLVERR), 32'h1);
    check_eq("il0_htrans", 32'(HTRANS), 32'h0);
    apb_idle();
    tick();

    // Reset during data phase
    apb_setup(16'h0050, 1'b1, 4'b1111, 32'h7777_7777, 3'b000);
    tick();
    PENABLE = 1'b1;
    tick();
    HREADY = 1'b0; RESET = 1'b1;
    tick();
    check_eq("rs_htrans", 32'(HTRANS), 32'h0);
    check_eq("rs_pready", 32'(PREADY), 32'h0);
    check_eq("rs_haddr", HADDR, 32'h0);
    check_eq("rs_hwdata", HWDATA, 32'h0);
    check_eq("rs_hprot", 32'(HPROT), 32'h3);
    RESET = 1'b0; HREADY = 1'b1; apb_idle();
    tick();
    apb_setup(16'h0060, 1'b1, 4'b1111, 32'h1122_3344, 3'b000);
    tick();
    check_eq("pr_htrans", 32'(HTRANS), 32'h2);
    check_eq("pr_haddr", HADDR, 32'h4001_0060);
    PENABLE = 1'b1;
    tick();
    check_eq("pr_hwdata", HWDATA, 32'h1122_3344);
    tick();
    check_eq("pr_pready", 32'(PREADY), 32'h1);
    check_eq("pr_pslverr", 32'(PSLVERR), 32'h0);

    // Back-to-back read immediately after the PREADY cycle
    tick();
    apb_setup(16'h0064, 1'b0, 4'b1111, 32'h0, 3'b000);
    HRDATA = 32'hA5A5_5A5A;
    tick();
    check_eq("bb_htrans", 32'(HTRANS), 32'h2);
    check_eq("bb_haddr", HADDR, 32'h4001_0064);
    PENABLE = 1'b1;
    tick();
    tick();
    check_eq("bb_pready", 32'(PREADY), 32'h1);
    check_eq("bb_prdata", PRDATA, 32'hA5A5_5A5A);
    apb_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
